key_matrix_scanner: RTL and testbench

KEY_MATRIX_SCANNER -- requirements
Module: key_matrix_scanner

---
 rtl/key_scan_pkg.sv | 25 ++
 rtl/event_fifo.sv | 60 ++++++
 rtl/key_matrix_scanner.sv | 143 ++++++++++++++
 tb/tb_key_matrix_scanner.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_scan_pkg.sv
// Shared defaults, event record type and row-drive helper for the key matrix
// scanner and its event queue.
package key_scan_pkg;

  localparam int ROW_CYCLES_DEF = 8192;
  localparam int SETTLE_DEF     = 16;
  localparam int DB_SCANS_DEF   = 4;
  localparam int FIFO_DEPTH_DEF = 8;

  localparam int EVT_CODE_W = 6;
  localparam int NUM_KEYS   = 64;

  typedef struct packed {
    logic [EVT_CODE_W-1:0] code;
    logic                  press;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  // Active-low one-cold row drive for the given row index.
  function automatic logic [7:0] rowDrive(input logic [2:0] idx);
    return ~(8'b0000_0001 << idx);
  endfunction

endpackage

// File: rtl/event_fifo.sv
// Synchronous first-in-first-out queue; a full queue still accepts a push when
// a pop happens in the same cycle.
module event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == L_DEPTH);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_data    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/key_matrix_scanner.sv
// 8x8 key matrix scanner: walks the rows, samples the columns once per dwell,
// debounces every key independently and queues press/release events.
module key_matrix_scanner
  import key_scan_pkg::*;
#(
  parameter int ROW_CYCLES = ROW_CYCLES_DEF,
  parameter int SETTLE     = SETTLE_DEF,
  parameter int DB_SCANS   = DB_SCANS_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [7:0]            row,
  input  logic [7:0]            col_in,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [EVT_CODE_W-1:0] evt_code,
  output logic                  evt_press,
  output logic [NUM_KEYS-1:0]   key_state,
  output logic                  overflow
);

  localparam int DW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam logic [DW-1:0] L_LAST       = DW'(ROW_CYCLES - 1);
  localparam logic [DW-1:0] L_SAMPLE     = DW'(SETTLE);
  localparam logic [DW-1:0] L_EVAL_FIRST = DW'(SETTLE + 1);
  localparam logic [DW-1:0] L_EVAL_LAST  = DW'(SETTLE + 8);
  localparam logic [3:0]    L_DB         = 4'(DB_SCANS);

  logic [7:0]          r_sync1;
  logic [7:0]          r_sync2;
  logic [2:0]          r_row_idx;
  logic [DW-1:0]       r_dwell;
  logic [7:0]          r_row;
  logic [7:0]          r_sample;
  logic [NUM_KEYS-1:0] r_key_state;
  logic [3:0]          r_db [NUM_KEYS];
  logic                r_overflow;

  logic                  w_in_eval;
  logic [2:0]            w_col;
  logic [EVT_CODE_W-1:0] w_key;
  logic [3:0]            w_db_inc;
  logic                  w_same;
  logic                  w_toggle;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_drop;
  evt_t                  w_push_evt;
  evt_t                  w_head;
  logic [EVT_W-1:0]      w_fifo_rdata;

  // Column c of the current row is judged at dwell SETTLE+1+c.
  assign w_in_eval = (r_dwell >= L_EVAL_FIRST) && (r_dwell <= L_EVAL_LAST);
  assign w_col     = 3'(r_dwell - L_EVAL_FIRST);
  assign w_key     = {r_row_idx, w_col};
  assign w_db_inc  = r_db[w_key] + 4'd1;
  assign w_same    = (r_sample[w_col] == r_key_state[w_key]);
  assign w_toggle  = w_in_eval && !w_same && (w_db_inc == L_DB);

  assign w_push_evt = '{code: w_key, press: ~r_key_state[w_key]};
  assign w_pop      = !w_empty && evt_ready;
  assign w_drop     = w_toggle && w_full && !w_pop;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= col_in;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row_idx <= 3'd0;
      r_dwell   <= '0;
      r_row     <= 8'hFE;
      r_sample  <= 8'h00;
    end else begin
      if (r_dwell == L_LAST) begin
        r_dwell   <= '0;
        r_row_idx <= r_row_idx + 3'd1;
        r_row     <= rowDrive(r_row_idx + 3'd1);
      end else begin
        r_dwell <= r_dwell + DW'(1);
      end
      if (r_dwell == L_SAMPLE) begin
        r_sample <= ~r_sync2;
      end
    end
  end

  // Any disagreement with the debounced state counts; agreement restarts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_key_state <= '0;
      r_overflow  <= 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_db[i] <= 4'd0;
      end
    end else begin
      if (w_in_eval) begin
        if (w_same || w_toggle) begin
          r_db[w_key] <= 4'd0;
        end else begin
          r_db[w_key] <= w_db_inc;
        end
        if (w_toggle) begin
          r_key_state[w_key] <= ~r_key_state[w_key];
        end
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVT_W)
  ) u_event_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_toggle),
    .i_data  (w_push_evt),
    .i_pop   (w_pop),
    .o_data  (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_head    = w_fifo_rdata;
  assign row       = r_row;
  assign evt_valid = !w_empty;
  assign evt_code  = w_head.code;
  assign evt_press = w_head.press;
  assign key_state = r_key_state;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_key_matrix_scanner.sv
// Directed bench for key_matrix_scanner: a keyboard model answers the row drive,
// and every handed-over event is logged with the cycle it was presented.
module tb_key_matrix_scanner;
  import key_scan_pkg::*;

  localparam int RC = 32;
  localparam int ST = 4;
  localparam int DB = 3;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  row;
  logic [7:0]  col_in;
  logic        evt_valid;
  logic        evt_ready;
  logic [5:0]  evt_code;
  logic        evt_press;
  logic [63:0] key_state;
  logic        overflow;

  logic [63:0] keyMatrix;
  int          edgeCnt;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int         edgeNo;
    logic [5:0] code;
    logic       press;
  } evtRec_t;

  typedef struct {
    int         edgeNo;
    logic [7:0] expRow;
    logic       expValid;
  } rowVec_t;

  evtRec_t capQ[$];
  evtRec_t expEvt[12];
  rowVec_t rowVec[11];

  key_matrix_scanner #(
    .ROW_CYCLES (RC),
    .SETTLE     (ST),
    .DB_SCANS   (DB),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col_in    (col_in),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_code  (evt_code),
    .evt_press (evt_press),
    .key_state (key_state),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release; the scan position follows from it.
  always @(posedge clk or negedge rst) begin
    if (!rst) edgeCnt <= 0;
    else      edgeCnt <= edgeCnt + 1;
  end

  // Keyboard model: a pressed key pulls its column low while its row is driven.
  always_comb begin
    col_in = 8'hFF;
    for (int r = 0; r < 8; r++) begin
      if (row[r] == 1'b0) begin
        for (int c = 0; c < 8; c++) begin
          if (keyMatrix[8*r+c]) col_in[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst && evt_valid && evt_ready) begin
      capQ.push_back('{edgeNo: edgeCnt, code: evt_code, press: evt_press});
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int r, input int c, input logic pressed);
    keyMatrix[8*r+c] = pressed;
  endtask

  task automatic goToEdge(input int target);
    for (int i = 0; i < 100000 && edgeCnt < target; i++) begin
      @(posedge clk);
      #1;
    end
    if (edgeCnt != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL goToEdge: got edge %0d, expected %0d", edgeCnt, target);
    end
  endtask

  initial begin
    rowVec[0]  = '{0,   8'hFE, 1'b0};
    rowVec[1]  = '{31,  8'hFE, 1'b0};
    rowVec[2]  = '{32,  8'hFD, 1'b0};
    rowVec[3]  = '{64,  8'hFB, 1'b0};
    rowVec[4]  = '{96,  8'hF7, 1'b0};
    rowVec[5]  = '{128, 8'hEF, 1'b0};
    rowVec[6]  = '{160, 8'hDF, 1'b0};
    rowVec[7]  = '{192, 8'hBF, 1'b0};
    rowVec[8]  = '{224, 8'h7F, 1'b0};
    rowVec[9]  = '{255, 8'h7F, 1'b0};
    rowVec[10] = '{256, 8'hFE, 1'b0};

    expEvt[0]  = '{843,  6'o25, 1'b1};
    expEvt[1]  = '{1611, 6'o25, 1'b0};
    expEvt[2]  = '{3718, 6'o40, 1'b1};
    expEvt[3]  = '{3721, 6'o43, 1'b1};
    expEvt[4]  = '{3725, 6'o47, 1'b1};
    expEvt[5]  = '{4486, 6'o40, 1'b0};
    expEvt[6]  = '{4489, 6'o43, 1'b0};
    expEvt[7]  = '{4493, 6'o47, 1'b0};
    expEvt[8]  = '{5400, 6'o31, 1'b1};
    expEvt[9]  = '{5401, 6'o32, 1'b1};
    expEvt[10] = '{5402, 6'o50, 1'b1};
    expEvt[11] = '{5403, 6'o66, 1'b1};

    evt_ready = 1'b1;
    keyMatrix = '0;
    rst       = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_row", 64'(row), 64'h00FE);
    checkOutput("reset_valid", 64'(evt_valid), 64'd0);
    checkOutput("reset_key_state", key_state, 64'd0);
    checkOutput("reset_overflow", 64'(overflow), 64'd0);
    #1 rst = 1'b1;

    // Idle scan: one frame of row walking with no keys down.
    for (int i = 0; i < 11; i++) begin
      goToEdge(rowVec[i].edgeNo);
      checkOutput($sformatf("row_walk@%0d", rowVec[i].edgeNo), 64'(row), 64'(rowVec[i].expRow));
      checkOutput($sformatf("idle_valid@%0d", rowVec[i].edgeNo), 64'(evt_valid),
                  64'(rowVec[i].expValid));
    end
    checkOutput("idle_events", 64'(capQ.size()), 64'd0);
    checkOutput("idle_key_state", key_state, 64'd0);

    // Key (2,5): press for three scans, then release for three scans.
    goToEdge(256);
    applyStimulus(2, 5, 1'b1);
    goToEdge(842);
    checkOutput("k25_before_valid", 64'(evt_valid), 64'd0);
    goToEdge(843);
    checkOutput("k25_valid", 64'(evt_valid), 64'd1);
    checkOutput("k25_code", 64'(evt_code), 64'(6'o25));
    checkOutput("k25_press", 64'(evt_press), 64'd1);
    goToEdge(844);
    checkOutput("k25_after_valid", 64'(evt_valid), 64'd0);
    checkOutput("k25_key_state", key_state, 64'd1 << 21);
    goToEdge(1024);
    applyStimulus(2, 5, 1'b0);
    goToEdge(1700);
    checkOutput("k25_release_state", key_state, 64'd0);
    checkOutput("k25_event_count", 64'(capQ.size()), 64'd2);

    // Key (1,0) bounces for only two scans.
    goToEdge(1792);
    applyStimulus(1, 0, 1'b1);
    goToEdge(2304);
    applyStimulus(1, 0, 1'b0);
    goToEdge(2900);
    checkOutput("bounce_key_state", key_state, 64'd0);
    checkOutput("bounce_event_count", 64'(capQ.size()), 64'd2);

    // Row 4 columns 0,3,7 together.
    goToEdge(3072);
    applyStimulus(4, 0, 1'b1);
    applyStimulus(4, 3, 1'b1);
    applyStimulus(4, 7, 1'b1);
    goToEdge(3730);
    checkOutput("row4_key_state", key_state, (64'd1 << 32) | (64'd1 << 35) | (64'd1 << 39));
    goToEdge(3840);
    applyStimulus(4, 0, 1'b0);
    applyStimulus(4, 3, 1'b0);
    applyStimulus(4, 7, 1'b0);
    goToEdge(4600);
    checkOutput("row4_event_count", 64'(capQ.size()), 64'd8);
    checkOutput("row4_release_state", key_state, 64'd0);

    // Five presses with the consumer stalled: the fifth is lost.
    goToEdge(4608);
    evt_ready = 1'b0;
    applyStimulus(3, 1, 1'b1);
    applyStimulus(3, 2, 1'b1);
    applyStimulus(5, 0, 1'b1);
    applyStimulus(6, 6, 1'b1);
    applyStimulus(7, 7, 1'b1);
    goToEdge(5230);
    checkOutput("stall_valid", 64'(evt_valid), 64'd1);
    checkOutput("stall_code_a", 64'(evt_code), 64'(6'o31));
    checkOutput("stall_press_a", 64'(evt_press), 64'd1);
    goToEdge(5300);
    checkOutput("stall_code_b", 64'(evt_code), 64'(6'o31));
    goToEdge(5350);
    checkOutput("stall_no_overflow", 64'(overflow), 64'd0);
    goToEdge(5360);
    checkOutput("stall_overflow", 64'(overflow), 64'd1);
    checkOutput("stall_code_c", 64'(evt_code), 64'(6'o31));
    checkOutput("stall_key_state", key_state,
                (64'd1 << 25) | (64'd1 << 26) | (64'd1 << 40) | (64'd1 << 54) | (64'd1 << 63));
    goToEdge(5400);
    evt_ready = 1'b1;
    goToEdge(5410);
    checkOutput("drain_valid", 64'(evt_valid), 64'd0);
    checkOutput("drain_event_count", 64'(capQ.size()), 64'd12);
    checkOutput("drain_overflow_sticky", 64'(overflow), 64'd1);

    // Reset with two releases queued and key (5,0) mid-debounce.
    goToEdge(5632);
    evt_ready = 1'b0;
    applyStimulus(3, 1, 1'b0);
    applyStimulus(3, 2, 1'b0);
    goToEdge(5888);
    applyStimulus(5, 0, 1'b0);
    goToEdge(6315);
    checkOutput("prerst_valid", 64'(evt_valid), 64'd1);
    checkOutput("prerst_code", 64'(evt_code), 64'(6'o31));
    checkOutput("prerst_press", 64'(evt_press), 64'd0);
    #2 rst = 1'b0;
    #1;
    checkOutput("rst_valid", 64'(evt_valid), 64'd0);
    checkOutput("rst_overflow", 64'(overflow), 64'd0);
    checkOutput("rst_row", 64'(row), 64'h00FE);
    checkOutput("rst_key_state", key_state, 64'd0);
    keyMatrix = '0;
    repeat (2) @(posedge clk);
    #3;
    rst       = 1'b1;
    evt_ready = 1'b1;
    goToEdge(31);
    checkOutput("rerun_row0", 64'(row), 64'h00FE);
    goToEdge(32);
    checkOutput("rerun_row1", 64'(row), 64'h00FD);
    goToEdge(800);
    checkOutput("rerun_no_stale", 64'(capQ.size()), 64'd12);
    checkOutput("rerun_valid", 64'(evt_valid), 64'd0);
    checkOutput("rerun_key_state", key_state, 64'd0);

    for (int i = 0; i < 12; i++) begin
      if (i < capQ.size()) begin
        checkOutput($sformatf("evt%0d_code", i), 64'(capQ[i].code), 64'(expEvt[i].code));
        checkOutput($sformatf("evt%0d_press", i), 64'(capQ[i].press), 64'(expEvt[i].press));
        checkOutput($sformatf("evt%0d_edge", i), 64'(capQ[i].edgeNo), 64'(expEvt[i].edgeNo));
      end else begin
        checks++;
        errors++;
        $display("[TB] FAIL evt%0d_missing: got %0d events, expected 12", i, capQ.size());
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
